// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
//   muldiv_op_t : HI/LO unit operation select (MULT, MULTU, DIV, DIVU)
//   muldiv_st_t : HI/LO unit sequencer state
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_st_t;

endpackage

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit.
// Iterative shift-add multiplier and restoring divider sharing one
// 2*WIDTH accumulator and one iteration counter. Fixed latency: the start
// edge, WIDTH iteration edges, then one sign-fix edge that writes HI/LO
// and pulses done.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, op       : begin operation op (muldiv_op_t encoding) when idle
//   rs_data/rt_data : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo      : write rs_data into HI / LO when idle
//   busy, done      : operation in progress, one-cycle completion pulse
//   hi, lo          : HI and LO registers
module hilo_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    muldiv_st_t          state;
    muldiv_op_t          op_t;
    logic [CW-1:0]       cnt;

    // Datapath: acc = {upper, lower}. Multiply: {partial product, multiplier}.
    // Divide: {remainder, dividend/quotient}. opnd holds the other magnitude.
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  acc_next;
    logic [WIDTH-1:0]    opnd;
    logic                is_div;
    logic                neg_lo;
    logic                neg_hi;

    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_trial;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo_fix;
    logic [WIDTH-1:0]    rem_fix;

    logic                accept;
    logic                signed_op;
    logic                div_op;
    logic                s_rs;
    logic                s_rt;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic             sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    assign op_t      = muldiv_op_t'(op);
    assign accept    = (state == ST_IDLE) && start;
    assign signed_op = (op_t == OP_MULT) || (op_t == OP_DIV);
    assign div_op    = (op_t == OP_DIV) || (op_t == OP_DIVU);
    assign s_rs      = signed_op && rs_data[WIDTH-1];
    assign s_rt      = signed_op && rt_data[WIDTH-1];

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        acc_next  = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            // Restoring step: keep the subtraction only if it did not borrow.
            if (!div_trial[WIDTH])
                acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    assign prod_fix = neg_lo ? -acc : acc;
    assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div <= div_op;
            // Divide by zero keeps an all-ones quotient unsigned and lets the
            // remainder reproduce the dividend, sign included.
            neg_lo <= div_op ? ((s_rs ^ s_rt) && (rt_data != '0)) : (s_rs ^ s_rt);
            neg_hi <= div_op && s_rs;
            acc    <= {{WIDTH{1'b0}}, div_op ? mag(rs_data, s_rs) : mag(rt_data, s_rt)};
            opnd   <= div_op ? mag(rt_data, s_rt) : mag(rs_data, s_rs);
        end else if (state == ST_RUN) begin
            acc    <= acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // start wins over a simultaneous mthi/mtlo
                        state <= ST_RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                ST_RUN: begin
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= ST_FIX;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                ST_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         mthi;
    logic         mtlo;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Issue one operation. The accepting edge counts as edge 1; edges returns
    // the edge number after which done was seen (0 if never within budget).
    // busy_e0 is busy sampled just after the accepting edge; pulse_after is
    // done sampled one edge after it was first seen.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int edges,
                          output logic busy_e0, output logic pulse_after);
        edges = 0;
        pulse_after = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0;
        busy_e0 = busy;
        for (int n = 2; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                edges = n;
                break;
            end
        end
        if (edges != 0) begin
            @(posedge clk); #1;
            pulse_after = done;
        end
    endtask

    task automatic write_hilo(input logic wh, input logic wl, input logic [W-1:0] v);
        @(negedge clk);
        mthi = wh; mtlo = wl; rs_data = v;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
        mthi = 1'b0; mtlo = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mthi_mtlo;
        write_hilo(1'b1, 1'b0, 32'hDEAD_BEEF);
        checks++;
        if (hi !== 32'hDEAD_BEEF || lo !== 32'h0) begin
            failures++;
            $display("FAIL mthi_only: hi=%h lo=%h, required deadbeef 00000000", hi, lo);
        end
        write_hilo(1'b0, 1'b1, 32'h0BAD_F00D);
        checks++;
        if (hi !== 32'hDEAD_BEEF || lo !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL mtlo_only: hi=%h lo=%h, required deadbeef 0badf00d", hi, lo);
        end
        write_hilo(1'b1, 1'b1, 32'h5555_AAAA);
        checks++;
        if (hi !== 32'h5555_AAAA || lo !== 32'h5555_AAAA) begin
            failures++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required 5555aaaa 5555aaaa", hi, lo);
        end
    endtask

    task automatic test_multu_max;
        int e; logic b0, p;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, b0, p);
        checks++;
        if (b0 !== 1'b1) begin
            failures++;
            $display("FAIL multu_busy: busy=%b after accept, required 1", b0);
        end
        checks++;
        if (e != 34) begin
            failures++;
            $display("FAIL multu_latency: done at edge %0d, required 34", e);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu_max: hi=%h lo=%h, required fffffffe 00000001", hi, lo);
        end
        checks++;
        if (p !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL multu_done_pulse: done=%b busy=%b next cycle, required 0 0", p, busy);
        end
    endtask

    task automatic test_mult_signed;
        int e; logic b0, p;
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, e, b0, p);
        checks++;
        if (e != 34 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            failures++;
            $display("FAIL mult_neg3x5: edge=%0d hi=%h lo=%h, required 34 ffffffff fffffff1", e, hi, lo);
        end
        run_op(2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, e, b0, p);
        checks++;
        if (hi !== 32'h0 || lo !== 32'd6) begin
            failures++;
            $display("FAIL mult_neg2xneg3: hi=%h lo=%h, required 00000000 00000006", hi, lo);
        end
        run_op(2'd1, 32'h8000_0000, 32'd4, e, b0, p);
        checks++;
        if (hi !== 32'h2 || lo !== 32'h0) begin
            failures++;
            $display("FAIL multu_carry: hi=%h lo=%h, required 00000002 00000000", hi, lo);
        end
    endtask

    task automatic test_divide;
        int e; logic b0, p;
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, e, b0, p);
        checks++;
        if (e != 34 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_neg7by2: edge=%0d hi=%h lo=%h, required 34 ffffffff fffffffd", e, hi, lo);
        end
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, e, b0, p);
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
            failures++;
            $display("FAIL div_7byneg2: hi=%h lo=%h, required 00000001 fffffffd", hi, lo);
        end
        run_op(2'd3, 32'd100, 32'd7, e, b0, p);
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            failures++;
            $display("FAIL divu_100by7: hi=%h lo=%h, required 00000002 0000000e", hi, lo);
        end
        run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0000, e, b0, p);
        checks++;
        if (lo !== 32'd1 || hi !== 32'h7FFF_FFFF) begin
            failures++;
            $display("FAIL divu_big: hi=%h lo=%h, required 7fffffff 00000001", hi, lo);
        end
    endtask

    task automatic test_div_corner;
        int e; logic b0, p;
        run_op(2'd3, 32'd7, 32'd0, e, b0, p);
        checks++;
        if (e != 34 || lo !== 32'hFFFF_FFFF || hi !== 32'h7) begin
            failures++;
            $display("FAIL divu_by_zero: edge=%0d hi=%h lo=%h, required 34 00000007 ffffffff", e, hi, lo);
        end
        run_op(2'd2, 32'hFFFF_FFF8, 32'd0, e, b0, p);
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF8) begin
            failures++;
            $display("FAIL div_neg_by_zero: hi=%h lo=%h, required fffffff8 ffffffff", hi, lo);
        end
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, e, b0, p);
        checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            failures++;
            $display("FAIL div_overflow: hi=%h lo=%h, required 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_busy_ignore;
        int e;
        logic [W-1:0] hi_before;
        logic [W-1:0] lo_before;
        hi_before = hi;
        lo_before = lo;
        // start with a simultaneous mthi: mthi must lose
        @(negedge clk);
        start = 1'b1; op = 2'd1; rs_data = 32'd3; rt_data = 32'd4; mthi = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        checks++;
        if (hi !== hi_before || lo !== lo_before) begin
            failures++;
            $display("FAIL start_over_mthi: hi=%h lo=%h, required %h %h", hi, lo, hi_before, lo_before);
        end
        repeat (4) @(posedge clk);
        #1;
        // second start plus mthi/mtlo mid-run
        start = 1'b1; op = 2'd2; rs_data = 32'd100; rt_data = 32'd7; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== hi_before || lo !== lo_before || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_mthi_ignored: hi=%h lo=%h busy=%b, required %h %h 1", hi, lo, busy, hi_before, lo_before);
        end
        e = 0;
        for (int n = 7; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                e = n;
                break;
            end
        end
        checks++;
        if (e != 34 || hi !== 32'd0 || lo !== 32'd12) begin
            failures++;
            $display("FAIL busy_start_ignored: edge=%0d hi=%h lo=%h, required 34 00000000 0000000c", e, hi, lo);
        end
    endtask

    task automatic test_reset_mid_run;
        logic seen_done;
        write_hilo(1'b1, 1'b1, 32'hA5A5_A5A5);
        @(negedge clk);
        start = 1'b1; op = 2'd1; rs_data = 32'd9; rt_data = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            failures++;
            $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || hi !== '0 || lo !== '0) begin
            failures++;
            $display("FAIL reset_discard: activity=%b hi=%h lo=%h, required 0 0 0", seen_done, hi, lo);
        end
        write_hilo(1'b1, 1'b0, 32'h1234_5678);
        checks++;
        if (hi !== 32'h1234_5678 || lo !== '0) begin
            failures++;
            $display("FAIL mthi_after_reset: hi=%h lo=%h, required 12345678 00000000", hi, lo);
        end
    endtask

    task automatic test_mthi_first_edge;
        // mthi presented for the very first edge after reset release
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rs_data = 32'hCAFE_0001; mthi = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0;
        checks++;
        if (hi !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL mthi_first_edge: hi=%h, required cafe0001", hi);
        end
    endtask

    initial begin
        test_reset;
        test_mthi_mtlo;
        test_multu_max;
        test_mult_signed;
        test_divide;
        test_div_corner;
        test_busy_ignore;
        test_reset_mid_run;
        test_mthi_first_edge;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
